post_process_pipe: RTL and testbench

//  Per-channel post-processing after the PE array / accumulator mux: bias add + ReLU, then BN scale (K) and shift (B).

---
 rtl/post_process_pkg.sv | 38 +++
 rtl/post_process_lane.sv | 51 +++++
 rtl/post_process_pipe.sv | 127 ++++++++++++
 tb/tb_post_process_pipe.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/post_process_pkg.sv
// Shared constants and fixed-point helpers for post_process_pipe.
// POSTPROC_SAT_EN selects saturating arithmetic; otherwise everything wraps modulo 2^DATA_W.
package post_process_pkg;

    localparam int unsigned DATA_W    = 16;
    localparam int unsigned INT_BITS  = 4;
    localparam int unsigned FRAC_BITS = DATA_W - INT_BITS;

    localparam logic [DATA_W-1:0] ONE_Q   = DATA_W'(1) << FRAC_BITS;
    localparam logic [DATA_W-1:0] MAX_POS = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] MIN_NEG = {1'b1, {(DATA_W-1){1'b0}}};

    function automatic logic [DATA_W-1:0] sat_add(input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] b);
`ifdef POSTPROC_SAT_EN
        logic [DATA_W:0] s;
        s = {a[DATA_W-1], a} + {b[DATA_W-1], b};
        // Top two bits disagree only on signed overflow.
        if (s[DATA_W] != s[DATA_W-1])
            return s[DATA_W] ? MIN_NEG : MAX_POS;
        return s[DATA_W-1:0];
`else
        return a + b;
`endif
    endfunction

    function automatic logic [DATA_W-1:0] sat_mul_shift(input logic [DATA_W-1:0] a,
                                                        input logic [DATA_W-1:0] k);
        logic signed [2*DATA_W-1:0] q;
        q = ($signed(a) * $signed(k)) >>> FRAC_BITS;
`ifdef POSTPROC_SAT_EN
        if (q[2*DATA_W-1:DATA_W-1] != {(DATA_W+1){q[2*DATA_W-1]}})
            return q[2*DATA_W-1] ? MIN_NEG : MAX_POS;
`endif
        return q[DATA_W-1:0];
    endfunction

endpackage

// File: rtl/post_process_lane.sv
// One lane of the 3-stage post-processing datapath: bias+ReLU, scale, shift.
// Arithmetic width and saturation mode come from post_process_pkg (POSTPROC_SAT_EN).
module post_process_lane
    import post_process_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ld1,
    input  logic              ld2,
    input  logic              ld3,
    input  logic [DATA_W-1:0] lane_in,
    input  logic [DATA_W-1:0] bias,
    input  logic [DATA_W-1:0] k,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] relu_out,
    output logic [DATA_W-1:0] data_out
);

    logic [DATA_W-1:0] sum1;
    logic [DATA_W-1:0] relu_nxt;
    logic [DATA_W-1:0] relu1;
    logic [DATA_W-1:0] relu2;
    logic [DATA_W-1:0] prod2;

    always_comb begin
        sum1     = sat_add(lane_in, bias);
        relu_nxt = sum1[DATA_W-1] ? '0 : sum1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            relu1    <= '0;
            relu2    <= '0;
            prod2    <= '0;
            relu_out <= '0;
            data_out <= '0;
        end else begin
            if (ld1)
                relu1 <= relu_nxt;
            if (ld2) begin
                relu2 <= relu1;
                prod2 <= sat_mul_shift(relu1, k);
            end
            if (ld3) begin
                relu_out <= relu2;
                data_out <= sat_add(prod2, b);
            end
        end
    end

endmodule

// File: rtl/post_process_pipe.sv
// Per-channel bias+ReLU and BN scale/shift over POX lanes, 3-stage valid/ready pipeline.
// Optional saturation is enabled by defining POSTPROC_SAT_EN.
module post_process_pipe
    import post_process_pkg::*;
#(
    parameter  int unsigned POX      = 4,
    parameter  int unsigned CH_DEPTH = 64,
    localparam int unsigned ADDR_W   = $clog2(CH_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [POX*DATA_W-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_last,
    input  logic                  ch_clr,
    input  logic [ADDR_W:0]       cfg_num_ch,
    input  logic                  cfg_we,
    input  logic [ADDR_W-1:0]     cfg_addr,
    input  logic [DATA_W-1:0]     cfg_bias,
    input  logic [DATA_W-1:0]     cfg_k,
    input  logic [DATA_W-1:0]     cfg_b,
    output logic [POX*DATA_W-1:0] out_relu,
    output logic [POX*DATA_W-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready
);

    logic v1, v2, v3;
    logic adv1, adv2, adv3;
    logic accept, ld2, ld3;

    logic [ADDR_W-1:0] ch_idx;
    logic [ADDR_W:0]   num_eff;
    logic              wr_ok;

    logic [DATA_W-1:0] tbl_bias [CH_DEPTH];
    logic [DATA_W-1:0] tbl_k    [CH_DEPTH];
    logic [DATA_W-1:0] tbl_b    [CH_DEPTH];

    logic [DATA_W-1:0] k_s1, b_s1, b_s2;

    // Each stage may take a new beat when it is empty or its successor is moving.
    assign adv3      = !v3 || out_ready;
    assign adv2      = !v2 || adv3;
    assign adv1      = !v1 || adv2;
    assign in_ready  = adv1;
    assign out_valid = v3;
    assign accept    = in_valid && adv1;
    assign ld2       = v1 && adv2;
    assign ld3       = v2 && adv3;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
            v3 <= 1'b0;
        end else begin
            if (adv1)
                v1 <= in_valid;
            if (adv2)
                v2 <= v1;
            if (adv3)
                v3 <= v2;
        end
    end

    assign num_eff = (cfg_num_ch == '0) ? (ADDR_W+1)'(1) : cfg_num_ch;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ch_idx <= '0;
        else if (ch_clr)
            ch_idx <= '0;
        else if (accept && in_last)
            ch_idx <= ({1'b0, ch_idx} == num_eff - (ADDR_W+1)'(1)) ? '0 : ch_idx + ADDR_W'(1);
    end

    assign wr_ok = cfg_we && (32'(cfg_addr) < 32'(CH_DEPTH));

    // Table reads are combinational from the pre-edge contents, so a same-cycle write is not seen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < CH_DEPTH; i++) begin
                tbl_bias[i] <= '0;
                tbl_k[i]    <= ONE_Q;
                tbl_b[i]    <= '0;
            end
        end else if (wr_ok) begin
            tbl_bias[cfg_addr] <= cfg_bias;
            tbl_k[cfg_addr]    <= cfg_k;
            tbl_b[cfg_addr]    <= cfg_b;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_s1 <= '0;
            b_s1 <= '0;
            b_s2 <= '0;
        end else begin
            if (accept) begin
                k_s1 <= tbl_k[ch_idx];
                b_s1 <= tbl_b[ch_idx];
            end
            if (ld2)
                b_s2 <= b_s1;
        end
    end

    for (genvar g = 0; g < POX; g++) begin : g_lane
        post_process_lane u_lane (
            .clk      (clk),
            .rst_n    (rst_n),
            .ld1      (accept),
            .ld2      (ld2),
            .ld3      (ld3),
            .lane_in  (in_data[g*DATA_W +: DATA_W]),
            .bias     (tbl_bias[ch_idx]),
            .k        (k_s1),
            .b        (b_s2),
            .relu_out (out_relu[g*DATA_W +: DATA_W]),
            .data_out (out_data[g*DATA_W +: DATA_W])
        );
    end

endmodule

// File: tb/tb_post_process_pipe.sv
// Self-checking bench for post_process_pipe: directed vectors, corner sequences, random vs. model.
// Define POSTPROC_SAT_EN for both bench and RTL to exercise the saturating build.
module tb_post_process_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic        in_last;
    logic        ch_clr;
    logic [6:0]  cfg_num_ch;
    logic        cfg_we;
    logic [5:0]  cfg_addr;
    logic [15:0] cfg_bias;
    logic [15:0] cfg_k;
    logic [15:0] cfg_b;
    logic [63:0] out_relu;
    logic [63:0] out_data;
    logic        out_valid;
    logic        out_ready;

    int n_tests = 0;
    int n_fail  = 0;

    post_process_pipe #(.POX(4), .CH_DEPTH(64)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_last    (in_last),
        .ch_clr     (ch_clr),
        .cfg_num_ch (cfg_num_ch),
        .cfg_we     (cfg_we),
        .cfg_addr   (cfg_addr),
        .cfg_bias   (cfg_bias),
        .cfg_k      (cfg_k),
        .cfg_b      (cfg_b),
        .out_relu   (out_relu),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got hang, required finish");
        $fatal(1, "watchdog");
    end

    // Output monitor: records every beat that fires at the next rising edge.
    logic        mon_en = 1'b1;
    logic [63:0] got_relu[$];
    logic [63:0] got_data[$];

    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (mon_en && out_valid && out_ready) begin
                got_relu.push_back(out_relu);
                got_data.push_back(out_data);
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // Reference arithmetic straight from the fixed-point rules.
    function automatic logic [15:0] fit(input longint v);
        logic [63:0] u;
`ifdef POSTPROC_SAT_EN
        if (v > 32767)  return 16'h7FFF;
        if (v < -32768) return 16'h8000;
`endif
        u = v;
        return u[15:0];
    endfunction

    function automatic longint sx(input logic [15:0] x);
        return longint'($signed(x));
    endfunction

    function automatic logic [31:0] ref_lane(input logic [15:0] lane, input logic [15:0] bias,
                                             input logic [15:0] k, input logic [15:0] b);
        logic [15:0] s, r, p, o;
        s = fit(sx(lane) + sx(bias));
        r = s[15] ? 16'h0000 : s;
        p = fit((sx(r) * sx(k)) >>> 12);
        o = fit(sx(p) + sx(b));
        return {r, o};
    endfunction

    task automatic cfg_write(input logic [5:0] a, input logic [15:0] bi, input logic [15:0] k,
                             input logic [15:0] b);
        @(negedge clk);
        cfg_we = 1'b1; cfg_addr = a; cfg_bias = bi; cfg_k = k; cfg_b = b;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    // Presents one beat and returns just after the edge that accepted it.
    task automatic send_beat(input logic [63:0] d, input logic last, input logic clr);
        int waited = 0;
        @(negedge clk);
        in_valid = 1'b1; in_data = d; in_last = last; ch_clr = clr;
        #1;
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            #1;
            waited++;
        end
        if (!in_ready) begin
            n_tests++; n_fail++;
            $display("FAIL send_beat: in_ready stuck, got 0, required 1");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0; in_last = 1'b0; ch_clr = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    typedef struct {
        string       name;
        logic [15:0] lane, bias, k, b, exp_relu, exp_out;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int          acc;
        int          lat;
        logic [15:0] bv;
        logic [15:0] exp_seq[9];
        logic [15:0] m_bias[64];
        logic [15:0] m_k[64];
        logic [15:0] m_b[64];
        int          m_ch;
        int          n_eff;
        logic [31:0] r;
        logic [63:0] er, eo;
        logic [63:0] exp_r[$];
        logic [63:0] exp_d[$];

        vecs[0] = '{"basic",     16'h0300, 16'h0200, 16'h1000, 16'h0100, 16'h0500, 16'h0600};
        vecs[1] = '{"relu_neg",  16'hF000, 16'h0100, 16'h1000, 16'h0100, 16'h0000, 16'h0100};
        vecs[2] = '{"scale2",    16'h1000, 16'h0000, 16'h2000, 16'hFF00, 16'h1000, 16'h1F00};
        vecs[3] = '{"scale_half",16'h0800, 16'h0800, 16'h0800, 16'h0000, 16'h1000, 16'h0800};
        vecs[4] = '{"floor_neg", 16'h0003, 16'h0000, 16'hF800, 16'h0000, 16'h0003, 16'hFFFE};
`ifdef POSTPROC_SAT_EN
        vecs[5] = '{"ovf_s1",    16'h7000, 16'h2000, 16'h2000, 16'h0100, 16'h7FFF, 16'h7FFF};
        vecs[6] = '{"ovf_s3",    16'h7000, 16'h0000, 16'h1000, 16'h2000, 16'h7000, 16'h7FFF};
`else
        vecs[5] = '{"ovf_s1",    16'h7000, 16'h2000, 16'h2000, 16'h0100, 16'h0000, 16'h0100};
        vecs[6] = '{"ovf_s3",    16'h7000, 16'h0000, 16'h1000, 16'h2000, 16'h7000, 16'h9000};
`endif

        rst_n = 1'b0; in_data = '0; in_valid = 1'b0; in_last = 1'b0; ch_clr = 1'b0;
        cfg_num_ch = 7'd1; cfg_we = 1'b0; cfg_addr = '0; cfg_bias = '0; cfg_k = '0; cfg_b = '0;
        out_ready = 1'b1;

        // Reset state
        wait_cycles(3);
        #1;
        check("rst out_valid", 64'(out_valid), 64'd0);
        check("rst out_data",  out_data, 64'd0);
        check("rst out_relu",  out_relu, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst in_ready", 64'(in_ready), 64'd1);

        // Directed vectors, one beat each on channel 0
        foreach (vecs[i]) begin
            cfg_write(6'd0, vecs[i].bias, vecs[i].k, vecs[i].b);
            send_beat({4{vecs[i].lane}}, 1'b1, 1'b0);
            lat = 1;
            while (!out_valid && lat < 10) begin
                @(posedge clk);
                #1;
                lat++;
            end
            check({vecs[i].name, " latency"}, 64'(lat), 64'd3);
            check({vecs[i].name, " relu"}, out_relu, {4{vecs[i].exp_relu}});
            check({vecs[i].name, " data"}, out_data, {4{vecs[i].exp_out}});
            wait_cycles(2);
        end

        // Stall: 5 cycles of out_ready low admit exactly 3 beats, then all 6 drain in order
        cfg_write(6'd0, 16'h0000, 16'h1000, 16'h0000);
        got_relu.delete(); got_data.delete();
        @(negedge clk);
        out_ready = 1'b0;
        acc = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            bv = 16'(17 * (acc + 1));
            in_valid = 1'b1; in_data = {4{bv}}; in_last = 1'b0;
            #1;
            if (in_ready) acc++;
        end
        check("stall accepted", 64'(acc), 64'd3);
        @(negedge clk);
        #1;
        check("stall in_ready", 64'(in_ready), 64'd0);
        for (int c = 0; c < 20 && acc < 6; c++) begin
            @(negedge clk);
            bv = 16'(17 * (acc + 1));
            out_ready = 1'b1; in_valid = 1'b1; in_data = {4{bv}};
            #1;
            if (in_ready) acc++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        wait_cycles(8);
        check("stall count", 64'(got_relu.size()), 64'd6);
        for (int i = 0; i < 6 && i < got_relu.size(); i++) begin
            bv = 16'(17 * (i + 1));
            check("stall order", got_relu[i], {4{bv}});
        end

        // Channel pointer wrap at num_ch=3, then ch_clr on the second beat
        cfg_num_ch = 7'd3;
        cfg_write(6'd0, 16'd1, 16'h1000, 16'h0000);
        cfg_write(6'd1, 16'd2, 16'h1000, 16'h0000);
        cfg_write(6'd2, 16'd3, 16'h1000, 16'h0000);
        @(negedge clk); ch_clr = 1'b1;
        @(negedge clk); ch_clr = 1'b0;
        got_relu.delete(); got_data.delete();
        for (int i = 0; i < 6; i++) send_beat(64'd0, 1'b1, 1'b0);
        send_beat(64'd0, 1'b1, 1'b0);
        send_beat(64'd0, 1'b1, 1'b1);
        send_beat(64'd0, 1'b1, 1'b0);
        wait_cycles(6);
        exp_seq = '{16'd1, 16'd2, 16'd3, 16'd1, 16'd2, 16'd3, 16'd1, 16'd2, 16'd1};
        check("chan count", 64'(got_relu.size()), 64'd9);
        for (int i = 0; i < 9 && i < got_relu.size(); i++)
            check("chan relu", got_relu[i], {4{exp_seq[i]}});

        // Table write in the same cycle a channel-0 beat is accepted
        cfg_num_ch = 7'd1;
        @(negedge clk); ch_clr = 1'b1;
        @(negedge clk); ch_clr = 1'b0;
        cfg_write(6'd0, 16'h0010, 16'h1000, 16'h0000);
        got_relu.delete(); got_data.delete();
        @(negedge clk);
        in_valid = 1'b1; in_data = '0; in_last = 1'b0;
        cfg_we = 1'b1; cfg_addr = 6'd0; cfg_bias = 16'h0020; cfg_k = 16'h1000; cfg_b = 16'h0005;
        #1;
        check("cfgrace in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        cfg_we = 1'b0; in_valid = 1'b0;
        send_beat(64'd0, 1'b0, 1'b0);
        wait_cycles(6);
        check("cfgrace count", 64'(got_relu.size()), 64'd2);
        if (got_relu.size() == 2) begin
            check("cfgrace old relu", got_relu[0], {4{16'h0010}});
            check("cfgrace old data", got_data[0], {4{16'h0010}});
            check("cfgrace new relu", got_relu[1], {4{16'h0020}});
            check("cfgrace new data", got_data[1], {4{16'h0025}});
        end

        // Asynchronous reset with three beats in flight
        cfg_write(6'd0, 16'h0100, 16'h1000, 16'h0000);
        @(negedge clk);
        out_ready = 1'b0;
        got_relu.delete(); got_data.delete();
        for (int i = 0; i < 3; i++) send_beat({4{16'(i + 1)}}, 1'b0, 1'b0);
        #2;
        check("pre-rst out_valid", 64'(out_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        check("async out_valid", 64'(out_valid), 64'd0);
        check("async out_data",  out_data, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        wait_cycles(10);
        check("post-rst outputs", 64'(got_relu.size()), 64'd0);
        #1;
        check("post-rst in_ready", 64'(in_ready), 64'd1);
        send_beat({4{16'h0300}}, 1'b0, 1'b0);
        wait_cycles(5);
        check("identity count", 64'(got_relu.size()), 64'd1);
        if (got_relu.size() == 1) begin
            check("identity relu", got_relu[0], {4{16'h0300}});
            check("identity data", got_data[0], {4{16'h0300}});
        end

        // Randomized traffic against a transaction-level model
        mon_en = 1'b0;
        for (int i = 0; i < 64; i++) begin
            m_bias[i] = 16'h0000; m_k[i] = 16'h1000; m_b[i] = 16'h0000;
        end
        m_ch = 0;
        cfg_num_ch = 7'd5;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            if (cyc == 1500) cfg_num_ch = 7'd0;
            in_valid  = ($urandom % 4) != 0;
            in_data   = {$urandom, $urandom};
            in_last   = ($urandom % 3) == 0;
            ch_clr    = (cyc == 0) || (($urandom % 64) == 0);
            out_ready = ($urandom % 4) != 0;
            cfg_we    = ($urandom % 8) == 0;
            cfg_addr  = 6'($urandom % 6);
            cfg_bias  = 16'($urandom);
            cfg_k     = 16'($urandom);
            cfg_b     = 16'($urandom);
            #1;
            check("rand in_ready", 64'(in_ready), 64'(!(exp_r.size() == 3 && !out_ready)));
            if (out_valid && out_ready) begin
                if (exp_r.size() == 0) begin
                    check("rand spurious out_valid", 64'(out_valid), 64'd0);
                end else begin
                    check("rand relu", out_relu, exp_r.pop_front());
                    check("rand data", out_data, exp_d.pop_front());
                end
            end
            if (in_valid && in_ready) begin
                for (int l = 0; l < 4; l++) begin
                    r = ref_lane(in_data[l*16 +: 16], m_bias[m_ch], m_k[m_ch], m_b[m_ch]);
                    er[l*16 +: 16] = r[31:16];
                    eo[l*16 +: 16] = r[15:0];
                end
                exp_r.push_back(er);
                exp_d.push_back(eo);
            end
            if (cfg_we) begin
                m_bias[cfg_addr] = cfg_bias; m_k[cfg_addr] = cfg_k; m_b[cfg_addr] = cfg_b;
            end
            n_eff = (cfg_num_ch == 0) ? 1 : int'(cfg_num_ch);
            if (ch_clr)
                m_ch = 0;
            else if (in_valid && in_ready && in_last)
                m_ch = (m_ch == n_eff - 1) ? 0 : (m_ch + 1) % 64;
        end
        @(negedge clk);
        in_valid = 1'b0; cfg_we = 1'b0; ch_clr = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 20 && exp_r.size() > 0; c++) begin
            #1;
            if (out_valid) begin
                check("drain relu", out_relu, exp_r.pop_front());
                check("drain data", out_data, exp_d.pop_front());
            end
            @(negedge clk);
        end
        check("drain leftover", 64'(exp_r.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
